fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the single-clock 32-bit FIFO between NUM_REQ requesters.

---
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready requesters.
// Latency : 1 IDLE arbitration cycle before each burst; beats then pass combinationally to wr_en/wr_data.
// Backpr. : full stalls the current beat (burst holds); almost_full ends a burst after its beat and blocks new grants.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/req_data  per-requester valid and packed data (requester i at [i*DATA_W +: DATA_W])
//   req_ready           per-requester beat-accepted strobe (only the granted requester can see 1)
//   full, almost_full   FIFO status inputs
//   wr_en, wr_data      FIFO write port
//   busy                high while a burst is in progress
//   grant_id            current or most recently granted requester
module fifo_wr_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 32,
  parameter  int MAX_BURST = 4,
  localparam int GW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW        = $clog2(MAX_BURST) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      full,
  input  logic                      almost_full,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      busy,
  output logic [GW-1:0]             grant_id
);

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gid_nxt;
  logic [GW-1:0] last_ptr, last_nxt;
  logic [CW-1:0] beat_cnt, cnt_nxt;

  logic          pick_vld;
  logic [GW-1:0] pick_idx;
  logic [GW-1:0] cand;
  logic          beat;

  // Round-robin search starting just after the last granted requester.
  // Walking the offsets from far to near lets the nearest valid requester
  // overwrite any earlier candidate, so it wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = GW'((int'(last_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt = state;
    gid_nxt   = grant_id;
    last_nxt  = last_ptr;
    cnt_nxt   = beat_cnt;
    beat      = 1'b0;
    wr_en     = 1'b0;
    req_ready = '0;
    wr_data   = '0;
    busy      = 1'b0;

    case (state)
      IDLE: begin
        if (pick_vld && !almost_full) begin
          gid_nxt   = pick_idx;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end

      BURST: begin
        busy               = 1'b1;
        wr_data            = req_data[grant_id*DATA_W +: DATA_W];
        beat               = req_valid[grant_id] && !full;
        wr_en              = beat;
        req_ready[grant_id] = beat;
        if (beat) begin
          cnt_nxt = beat_cnt + CW'(1);
        end
        // Release on: burst length reached, requester withdrew, or FIFO
        // nearly full (the current beat still goes in).
        if (!req_valid[grant_id] ||
            (beat && ((beat_cnt == CW'(MAX_BURST - 1)) || almost_full))) begin
          state_nxt = IDLE;
          last_nxt  = grant_id;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      grant_id <= '0;
      last_ptr <= GW'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= gid_nxt;
      last_ptr <= last_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Purpose : directed self-checking bench for fifo_wr_arbiter (4 requesters, 32-bit, bursts of 4).
// Latency : inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Backpr. : requesters are modelled as beat counters that advance only when req_ready was seen.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]   req_ready;
  logic            full = 1'b0;
  logic            almost_full = 1'b0;
  logic            wr_en;
  logic [DW-1:0]   wr_data;
  logic            busy;
  logic [1:0]      grant_id;

  int checks = 0;
  int errors = 0;

  // Requester model: rem = beats still to send, nxt = data of next beat.
  int          rem [NR];
  logic [31:0] nxt [NR];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .almost_full(almost_full),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (rem[i] > 0);
      req_data[i*DW +: DW] = nxt[i];
    end
  endtask

  // Advance one cycle: beats accepted before the edge consume requester data.
  task automatic tick();
    logic [NR-1:0] acc;
    acc = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        rem[i]--;
        nxt[i]++;
      end
    end
    upd();
    @(negedge clk);
  endtask

  task automatic expect_beat(input int g, input logic [31:0] d);
    chk("beat_wr_en", 32'(wr_en), 32'd1);
    chk("beat_busy", 32'(busy), 32'd1);
    chk("beat_grant", 32'(grant_id), 32'(g));
    chk("beat_ready", 32'(req_ready), 32'(1 << g));
    chk("beat_data", wr_data, d);
    tick();
  endtask

  task automatic expect_idle();
    chk("idle_wr_en", 32'(wr_en), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd0);
    chk("idle_data", wr_data, 32'd0);
    tick();
  endtask

  // Burst held but no beat (FIFO full or requester withdrew).
  task automatic expect_hold(input int g);
    chk("hold_wr_en", 32'(wr_en), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_ready", 32'(req_ready), 32'd0);
    chk("hold_grant", 32'(grant_id), 32'(g));
    tick();
  endtask

  // Enter reset, check reset outputs; returns at a falling edge with rst still low.
  task automatic do_reset();
    for (int i = 0; i < NR; i++) begin
      rem[i] = 0;
      nxt[i] = '0;
    end
    upd();
    full        = 1'b0;
    almost_full = 1'b0;
    rst         = 1'b0;
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    // ---- 1: single requester, 6 beats -> 4 + idle + 2 ----
    do_reset();
    rem[0] = 6; nxt[0] = 32'hA0; upd();
    rst = 1'b1; #1;
    expect_idle();
    expect_beat(0, 32'hA0);
    expect_beat(0, 32'hA1);
    expect_beat(0, 32'hA2);
    expect_beat(0, 32'hA3);
    expect_idle();
    expect_beat(0, 32'hA4);
    expect_beat(0, 32'hA5);
    expect_hold(0);          // valid dropped: burst closes without a beat
    expect_idle();

    // ---- 2: all valid, rotation 0,1,2,3,0 with 4 beats each ----
    do_reset();
    for (int i = 0; i < NR; i++) begin
      rem[i] = 8;
      nxt[i] = 32'h1000 * (i + 1);
    end
    upd();
    rst = 1'b1; #1;
    expect_idle();
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < 4; b++) begin
        expect_beat(r % NR, 32'h1000 * ((r % NR) + 1) + ((r == 4) ? 4 : 0) + b);
      end
      expect_idle();
    end

    // ---- 3: requester 2, full for 3 cycles mid-burst ----
    do_reset();
    rem[2] = 4; nxt[2] = 32'hC0; upd();
    rst = 1'b1; #1;
    expect_idle();
    expect_beat(2, 32'hC0);
    expect_beat(2, 32'hC1);
    full = 1'b1; #1;
    expect_hold(2);
    expect_hold(2);
    expect_hold(2);
    full = 1'b0; #1;
    expect_beat(2, 32'hC2);
    expect_beat(2, 32'hC3);
    expect_idle();

    // ---- 4: almost_full during beat 2 ----
    do_reset();
    rem[0] = 8; nxt[0] = 32'hD0; upd();
    rst = 1'b1; #1;
    expect_idle();
    expect_beat(0, 32'hD0);
    almost_full = 1'b1; #1;
    expect_beat(0, 32'hD1);  // written, then released
    expect_idle();
    expect_idle();
    expect_idle();
    almost_full = 1'b0; #1;
    expect_idle();           // arbitration cycle
    expect_beat(0, 32'hD2);

    // ---- 5: requester 1 withdraws after 2 beats; next grant goes to 2 ----
    do_reset();
    rem[1] = 2; nxt[1] = 32'hE0;
    rem[2] = 4; nxt[2] = 32'hF0;
    upd();
    rst = 1'b1; #1;
    expect_idle();
    expect_beat(1, 32'hE0);
    expect_beat(1, 32'hE1);
    expect_hold(1);
    rem[1] = 4; upd(); #1;   // requester 1 comes back but must wait its turn
    expect_idle();
    expect_beat(2, 32'hF0);

    // ---- 6: async reset mid-burst, then requester 0 has priority ----
    chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wr_en", 32'(wr_en), 32'd0);
    chk("arst_ready", 32'(req_ready), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", wr_data, 32'd0);
    rem[0] = 2; nxt[0] = 32'h60; upd();
    @(negedge clk);
    rst = 1'b1; #1;
    expect_idle();
    expect_beat(0, 32'h60);
    expect_beat(0, 32'h61);
    expect_hold(0);
    expect_idle();
    expect_beat(1, 32'hE2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
